// File: rtl/cacheline_adaptor_if.sv
// Cacheline adaptor bus: arbiter line port plus memory burst port in one bundle.
// Ports (adaptor view): read_i/write_i/address_i/line_i from arbiter, line_o/resp_o back;
//   burst_i/resp_i from memory, burst_o/address_o/read_o/write_o to memory.
interface cacheline_adaptor_if #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64
) ();
  // Arbiter side
  logic                   read_i;
  logic                   write_i;
  logic [31:0]            address_i;
  logic [LINE_WIDTH-1:0]  line_i;
  logic [LINE_WIDTH-1:0]  line_o;
  logic                   resp_o;
  // Memory side
  logic [BURST_WIDTH-1:0] burst_i;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [31:0]            address_o;
  logic                   read_o;
  logic                   write_o;
  logic                   resp_i;

  // The adaptor itself
  modport slave (
    input  read_i, write_i, address_i, line_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  // Whatever drives the adaptor (arbiter + memory model)
  modport master (
    output read_i, write_i, address_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Cacheline adaptor: turns one 256-bit line read/write into a 4-beat 64-bit memory burst.
// Latency: request sampled at edge t, read_o/write_o from t+1, resp_o pulse at t+5 minimum.
// Backpressure: memory paces beats with resp_i (gaps allowed); arbiter holds its request until resp_o.
// Ports: clk, rst (sync, active-high), bus (cacheline_adaptor_if.slave); all outputs registered.
module cacheline_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int BEATS       = 4
) (
  input  logic               clk,
  input  logic               rst,
  cacheline_adaptor_if.slave bus
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;
  // Line viewed as an array of beats; index 0 is the low beat (little-endian order).
  typedef logic [BEATS-1:0][BURST_WIDTH-1:0] line_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  line_t                  lbuf_q, lbuf_d;
  line_t                  line_q, line_d;
  logic [31:0]            addr_q, addr_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic                   read_q, read_d;
  logic                   write_q, write_d;
  logic                   resp_q, resp_d;
  logic                   last_beat;

  // Address low bits are cleared on latch; keep them visibly consumed.
  logic unused_addr_lo;
  assign unused_addr_lo = ^bus.address_i[4:0];

  assign last_beat = (cnt_q == CW'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lbuf_d  = lbuf_q;
    line_d  = line_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        // Write wins when both requests are raised together.
        if (bus.write_i) begin
          state_d = WR_BURST;
          lbuf_d  = bus.line_i;
          addr_d  = {bus.address_i[31:5], 5'b0};
          cnt_d   = '0;
        end else if (bus.read_i) begin
          state_d = RD_BURST;
          addr_d  = {bus.address_i[31:5], 5'b0};
          cnt_d   = '0;
        end
      end
      RD_BURST: begin
        if (bus.resp_i) begin
          lbuf_d[cnt_q] = bus.burst_i;
          if (last_beat) begin
            state_d = DONE;
            cnt_d   = '0;
            // Separate output copy so a later write cannot disturb line_o.
            line_d  = lbuf_d;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WR_BURST: begin
        if (bus.resp_i) begin
          if (last_beat) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are pure functions of the next state, registered below (Moore).
    read_d  = (state_d == RD_BURST);
    write_d = (state_d == WR_BURST);
    resp_d  = (state_d == DONE);
    burst_d = (state_d == WR_BURST) ? lbuf_d[cnt_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lbuf_q  <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      burst_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lbuf_q  <= lbuf_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      read_q  <= read_d;
      write_q <= write_d;
      resp_q  <= resp_d;
    end
  end

  assign bus.line_o    = line_q;
  assign bus.resp_o    = resp_q;
  assign bus.burst_o   = burst_q;
  assign bus.address_o = addr_q;
  assign bus.read_o    = read_q;
  assign bus.write_o   = write_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reads (with/without gaps), writes, priority/drop,
// mid-burst reset and spurious memory strobes; bench plays both arbiter and memory.
// Inputs change and outputs are sampled on the falling edge, away from the active edge.
module tb_cacheline_adaptor;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cacheline_adaptor_if #(.LINE_WIDTH(256), .BURST_WIDTH(64)) bus_if ();

  cacheline_adaptor #(.LINE_WIDTH(256), .BURST_WIDTH(64), .BEATS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "/resp"},  bus_if.resp_o,  1'b0);
    chk({tag, "/read"},  bus_if.read_o,  1'b0);
    chk({tag, "/write"}, bus_if.write_o, 1'b0);
  endtask

  // Full read transaction; pat[c]=1 means memory delivers the next beat in burst cycle c.
  task automatic run_read(input string tag, input logic [31:0] addr, input logic [255:0] mem_line,
                          input logic [15:0] pat, input int plen);
    int k;
    logic [31:0] exp_addr;
    exp_addr = {addr[31:5], 5'b0};
    bus_if.read_i    = 1'b1;
    bus_if.address_i = addr;
    step();
    bus_if.address_i = 32'hFFFF_FFFF; // must not affect a latched request
    k = 0;
    for (int c = 0; c < plen; c++) begin
      chk({tag, "/read_o"}, bus_if.read_o, 1'b1);
      chk({tag, "/addr_o"}, bus_if.address_o, exp_addr);
      chk({tag, "/resp_early"}, bus_if.resp_o, 1'b0);
      bus_if.resp_i  = pat[c];
      bus_if.burst_i = pat[c] ? mem_line[k*64 +: 64] : 64'hDEAD_BEEF_DEAD_BEEF;
      if (pat[c]) k++;
      step();
    end
    bus_if.resp_i = 1'b0;
    chk({tag, "/resp"}, bus_if.resp_o, 1'b1);
    chk({tag, "/read_done"}, bus_if.read_o, 1'b0);
    chk({tag, "/line"}, bus_if.line_o, mem_line);
    bus_if.read_i = 1'b0;
    step();
    chk({tag, "/resp_1cyc"}, bus_if.resp_o, 1'b0);
    chk({tag, "/line_held"}, bus_if.line_o, mem_line);
  endtask

  // Full write transaction; write_i drops once drop_after beats are accepted (-1: never),
  // also_rd raises read_i alongside write_i to exercise priority.
  task automatic run_write(input string tag, input logic [31:0] addr, input logic [255:0] wline,
                           input logic [15:0] pat, input int plen, input int drop_after,
                           input bit also_rd, input logic [255:0] prev_line);
    int k;
    bus_if.write_i   = 1'b1;
    bus_if.read_i    = also_rd;
    bus_if.address_i = addr;
    bus_if.line_i    = wline;
    step();
    bus_if.line_i    = ~wline;
    bus_if.address_i = 32'h0;
    k = 0;
    for (int c = 0; c < plen; c++) begin
      chk({tag, "/write_o"}, bus_if.write_o, 1'b1);
      chk({tag, "/no_read"}, bus_if.read_o, 1'b0);
      chk({tag, "/addr_o"}, bus_if.address_o, {addr[31:5], 5'b0});
      chk({tag, "/burst_o"}, bus_if.burst_o, wline[k*64 +: 64]);
      chk({tag, "/resp_early"}, bus_if.resp_o, 1'b0);
      bus_if.resp_i = pat[c];
      if (pat[c]) k++;
      step();
      if (k == drop_after) bus_if.write_i = 1'b0;
    end
    bus_if.resp_i = 1'b0;
    chk({tag, "/resp"}, bus_if.resp_o, 1'b1);
    chk({tag, "/write_done"}, bus_if.write_o, 1'b0);
    chk({tag, "/no_read_done"}, bus_if.read_o, 1'b0);
    chk({tag, "/line_kept"}, bus_if.line_o, prev_line);
    bus_if.write_i = 1'b0;
    bus_if.read_i  = 1'b0;
    step();
    chk_idle_outs({tag, "/after"});
  endtask

  logic [255:0] l1, l2, l3, lw, lw2;

  initial begin
    l1  = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    l2  = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
           64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
    l3  = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
           64'h0F0F_0F0F_F0F0_F0F0, 64'h5555_AAAA_5555_AAAA};
    lw  = {64'h3333_3333_0000_0003, 64'h2222_2222_0000_0002,
           64'h1111_1111_0000_0001, 64'h0000_0000_0000_0000};
    lw2 = {64'h9999_0000_0000_0009, 64'h8888_0000_0000_0008,
           64'h7777_0000_0000_0007, 64'h6666_0000_0000_0006};

    rst = 1'b1;
    bus_if.read_i = 1'b0; bus_if.write_i = 1'b0; bus_if.address_i = '0;
    bus_if.line_i = '0;   bus_if.burst_i = '0;   bus_if.resp_i = 1'b0;
    step();
    step();
    chk_idle_outs("reset");
    chk("reset/line", bus_if.line_o, '0);
    chk("reset/burst", bus_if.burst_o, '0);
    chk("reset/addr", bus_if.address_o, '0);
    rst = 1'b0;

    // Spurious strobes while idle must not start anything or advance the counter.
    bus_if.resp_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle_outs("spurious");
    end
    bus_if.resp_i = 1'b0;

    run_read("rd_nostall", 32'h0000_1234, l1, 16'b1111, 4);
    run_read("rd_gaps", 32'h0000_5FFF, l2, 16'b1011001, 7);
    run_write("wr", 32'h8000_0040, lw, 16'b1111, 4, -1, 1'b0, l2);
    run_write("wr_prio_drop", 32'h0000_0123, lw2, 16'b10111, 5, 2, 1'b1, l2);

    // Reset after two read beats: burst is abandoned with no response.
    bus_if.read_i = 1'b1;
    bus_if.address_i = 32'h0000_4444;
    step();
    bus_if.resp_i = 1'b1;
    bus_if.burst_i = 64'h1;
    step();
    bus_if.burst_i = 64'h2;
    step();
    rst = 1'b1;
    step();
    chk_idle_outs("midrst");
    chk("midrst/line", bus_if.line_o, '0);
    chk("midrst/addr", bus_if.address_o, '0);
    chk("midrst/burst", bus_if.burst_o, '0);
    rst = 1'b0;
    bus_if.read_i = 1'b0;
    bus_if.resp_i = 1'b0;
    step();
    chk_idle_outs("midrst/post");
    run_read("rd_after_rst", 32'h0000_4444, l3, 16'b1111, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
Memory-side responder for the cache arbiter's line interface.
- Accepts one 256-bit cacheline read or write request at a time from the arbiter.
- Executes each request as a 4-beat, 64-bit burst to physical memory/DRAM.
- Raises a single-cycle line response when the burst completes.
- Sits between the arbiter's read_request/write_request/address/data/resp port and the burst memory model.

Parameters:
LINE_WIDTH, 256, cacheline width in bits; must equal BURST_WIDTH*BEATS.
BURST_WIDTH, 64, data width of one memory beat.
BEATS, 4, beats per line; beat counter width is clog2(BEATS).

Ports:
clk  input  1  system clock; single clock domain.
rst  input  1  reset; synchronous, active-high.
read_i  input  1  line read request from arbiter; held until resp_o.
write_i  input  1  line write request from arbiter; held until resp_o.
address_i  input  32  line address from arbiter.
line_i  input  LINE_WIDTH  write line from arbiter.
line_o  output  LINE_WIDTH  assembled read line to arbiter.
resp_o  output  1  one-cycle completion pulse to arbiter.
burst_i  input  BURST_WIDTH  read beat from memory.
burst_o  output  BURST_WIDTH  write beat to memory.
address_o  output  32  burst address to memory, line-aligned.
read_o  output  1  burst read request to memory.
write_o  output  1  burst write request to memory.
resp_i  input  1  memory beat strobe; one beat transferred per cycle it is high.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, beat counter 0, line buffer 0, address register 0; line_o=0, burst_o=0, address_o=0, read_o=0, write_o=0, resp_o=0.
- Reset mid-burst: abandon the burst, restore reset values, emit no resp_o.
- States: IDLE, RD_BURST, WR_BURST, DONE. Control outputs are decoded from state only (Moore).
- IDLE:
  - write_i=1 -> WR_BURST; latch line_i into the buffer; latch address_i with bits[4:0] cleared; counter=0. Write takes priority if read_i and write_i are both high.
  - Otherwise read_i=1 -> RD_BURST; latch the aligned address; counter=0.
  - resp_i is ignored in IDLE.
- RD_BURST:
  - read_o=1; address_o = latched address.
  - Each cycle resp_i=1: write burst_i into buffer bits [64k+63:64k], where k is the counter, then increment the counter.
  - Cycles with resp_i=0 are stalls; gaps between beats are legal.
  - When the beat at k=BEATS-1 is accepted, go to DONE. read_o is low from DONE onward.
- WR_BURST:
  - write_o=1; burst_o = buffer bits [64k+63:64k].
  - Each cycle resp_i=1 increments the counter.
  - After beat BEATS-1 is accepted, go to DONE.
- DONE:
  - resp_o=1 for exactly one cycle, then IDLE.
  - line_o = buffer. line_o is held stable after DONE until the next read overwrites the buffer.
- Request drops mid-burst: read_i/write_i deasserting before resp_o is ignored; the burst completes and resp_o still pulses.
- Beat order: little-endian; beat 0 is the low 64 bits.
- Latency: request sampled at edge t -> read_o/write_o high from cycle t+1. With back-to-back resp_i on cycles t+1..t+4, resp_o is high in cycle t+5. Minimum request-to-response latency is 5 cycles.
- Back-to-back requests: the cycle after DONE is IDLE and samples requests normally. A request held over from the prior transaction restarts; the arbiter drops its request on resp_o.
- address_i and line_i changes after the request is latched have no effect.
- Counter wraps to 0 on entry to each burst; it never exceeds BEATS-1.

Test Plan:
- Read, no stalls: read_i=1, address_i=0x0000_1234; resp_i high for 4 cycles with burst_i=0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o=0x0000_1220, read_o high 4 cycles, resp_o pulses in cycle 5, line_o={0x44..44,0x33..33,0x22..22,0x11..11}.
- Read with gaps: resp_i pattern 1,0,0,1,1,0,1 with beats A,B,C,D -> line_o={D,C,B,A}, resp_o exactly one cycle after the 7th burst cycle, read_o high throughout the burst.
- Write: write_i=1, address_i=0x8000_0040, line_i={W3,W2,W1,W0}; resp_i high 4 cycles -> burst_o=W0,W1,W2,W3 on successive beats, write_o high 4 cycles, one resp_o pulse.
- Simultaneous request with drop: read_i=write_i=1 in IDLE -> write burst performed; deassert write_i after beat 1 -> burst still completes, resp_o=1 once, read_o never high.
- Reset mid-burst: rst=1 after 2 read beats -> next cycle all outputs 0, state IDLE; subsequent read_i completes a full 4-beat transaction with a correct line.
- Spurious resp_i: resp_i=1 while IDLE with no request -> no state change, resp_o stays 0, counter stays 0.
